ntt_op_sequencer: RTL and testbench

Control sequencer for the ML-KEM polynomial arithmetic unit. On a start pulse it issues, one per handshake, the butterfly / base-case operations for one polynomial: coefficient address pair, zeta value and layer tags. It covers forward NTT (FIPS 203 Alg 9), inverse NTT (Alg 10, excluding the final 3303 scaling) and MultiplyNTTs pairing (Alg 11). It sits between the top-level command FSM and the butterfly datapath/coefficient RAM, and inserts pipeline-drain bubbles between dependent layers.

---
 rtl/ntt_op_sequencer_pkg.sv | 56 +++++
 rtl/ntt_op_sequencer_if.sv | 23 ++
 rtl/ntt_op_sequencer_addr_gen.sv | 27 ++
 rtl/ntt_op_sequencer.sv | 94 +++++++++
 tb/tb_ntt_op_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ntt_op_sequencer_pkg.sv
// ntt_op_sequencer_pkg: shared types, sizes and zeta tables for the ML-KEM polynomial op sequencer.
package ntt_op_sequencer_pkg;
   typedef logic [11:0] coeff_t;
   typedef enum logic [1:0] {MODE_NTT = 2'd0, MODE_INTT = 2'd1, MODE_MUL = 2'd2} op_mode_t;
   localparam int NTT_LAYERS = 7;
   localparam int OPS_PER_LAYER = 128;
   typedef struct packed {
      logic [7:0] addr_a;
      logic [7:0] addr_b;
      coeff_t     zeta;
      logic [2:0] layer;
      logic       layer_last;
      logic       op_last;
   } bf_op_t;
   // zeta^BitRev7(k) mod 3329
   localparam coeff_t ZETA_NTT_TABLE [128] = '{
      1, 1729, 2580, 3289, 2642, 630, 1897, 848,
      1062, 1919, 193, 797, 2786, 3260, 569, 1746,
      296, 2447, 1339, 1476, 3046, 56, 2240, 1333,
      1426, 2094, 535, 2882, 2393, 2879, 1974, 821,
      289, 331, 3253, 1756, 1197, 2304, 2277, 2055,
      650, 1977, 2513, 632, 2865, 33, 1320, 1915,
      2319, 1435, 807, 452, 1438, 2868, 1534, 2402,
      2647, 2617, 1481, 648, 2474, 3110, 1227, 910,
      17, 2761, 583, 2649, 1637, 723, 2288, 1100,
      1409, 2662, 3281, 233, 756, 2156, 3015, 3050,
      1703, 1651, 2789, 1789, 1847, 952, 1461, 2687,
      939, 2308, 2437, 2388, 733, 2337, 268, 641,
      1584, 2298, 2037, 3220, 375, 2549, 2090, 1645,
      1063, 319, 2773, 757, 2099, 561, 2466, 2594,
      2804, 1092, 403, 1026, 1143, 2150, 2775, 886,
      1722, 1212, 1874, 1029, 2110, 2935, 885, 2154
   };
   // base-case gammas: pairs of +/- zeta^(2*BitRev7(i)+1)
   localparam coeff_t ZETA_MUL_TABLE [128] = '{
      17, 3312, 2761, 568, 583, 2746, 2649, 680,
      1637, 1692, 723, 2606, 2288, 1041, 1100, 2229,
      1409, 1920, 2662, 667, 3281, 48, 233, 3096,
      756, 2573, 2156, 1173, 3015, 314, 3050, 279,
      1703, 1626, 1651, 1678, 2789, 540, 1789, 1540,
      1847, 1482, 952, 2377, 1461, 1868, 2687, 642,
      939, 2390, 2308, 1021, 2437, 892, 2388, 941,
      733, 2596, 2337, 992, 268, 3061, 641, 2688,
      1584, 1745, 2298, 1031, 2037, 1292, 3220, 109,
      375, 2954, 2549, 780, 2090, 1239, 1645, 1684,
      1063, 2266, 319, 3010, 2773, 556, 757, 2572,
      2099, 1230, 561, 2768, 2466, 863, 2594, 735,
      2804, 525, 1092, 2237, 403, 2926, 1026, 2303,
      1143, 2186, 2150, 1179, 2775, 554, 886, 2443,
      1722, 1607, 1212, 2117, 1874, 1455, 1029, 2300,
      2110, 1219, 2935, 394, 885, 2444, 2154, 1175
   };
   function automatic logic [2:0] final_layer(op_mode_t m);
      return (m == MODE_MUL) ? 3'd0 : 3'(NTT_LAYERS - 1);
   endfunction
endpackage

// File: rtl/ntt_op_sequencer_if.sv
// ntt_op_sequencer_if: command and operation-issue signals between command FSM, sequencer and datapath.
interface ntt_op_sequencer_if;
   logic                         start_i;
   logic [1:0]                   mode_i;
   logic                         busy_o;
   logic                         done_o;
   logic                         op_valid_o;
   logic                         op_ready_i;
   logic [7:0]                   addr_a_o;
   logic [7:0]                   addr_b_o;
   ntt_op_sequencer_pkg::coeff_t zeta_o;
   logic [2:0]                   layer_o;
   logic                         op_last_o;
   logic                         layer_last_o;
   modport master (
      input  start_i, mode_i, op_ready_i,
      output busy_o, done_o, op_valid_o, addr_a_o, addr_b_o, zeta_o, layer_o, op_last_o, layer_last_o
   );
   modport slave (
      output start_i, mode_i, op_ready_i,
      input  busy_o, done_o, op_valid_o, addr_a_o, addr_b_o, zeta_o, layer_o, op_last_o, layer_last_o
   );
endinterface

// File: rtl/ntt_op_sequencer_addr_gen.sv
// ntt_addr_gen: combinational (mode, layer, op) to coefficient address pair and zeta table index.
module ntt_addr_gen
   import ntt_op_sequencer_pkg::*;
(
   input  op_mode_t   mode_i,
   input  logic [2:0] layer_i,
   input  logic [6:0] op_i,
   output logic [7:0] addr_a_o,
   output logic [7:0] addr_b_o,
   output logic [6:0] zeta_idx_o
);
   logic [2:0] sh;
   logic [7:0] len;
   logic [7:0] grp;
   logic [7:0] base;
   // sh = log2(len); group base is 2*len*grp, offset is the low bits of op
   always_comb begin
      sh = (mode_i == MODE_NTT) ? 3'd7 - layer_i : layer_i + 3'd1;
      len = 8'd1 << sh;
      grp = {1'b0, op_i} >> sh;
      base = ((grp << sh) << 1) | ({1'b0, op_i} & (len - 8'd1));
      addr_a_o = (mode_i == MODE_MUL) ? {op_i, 1'b0} : base;
      addr_b_o = (mode_i == MODE_MUL) ? {op_i, 1'b1} : base + len;
      zeta_idx_o = (mode_i == MODE_MUL) ? op_i :
                   (mode_i == MODE_NTT) ? 7'((8'd128 >> sh) + grp) : 7'((8'd255 >> sh) - grp);
   end
endmodule

// File: rtl/ntt_op_sequencer.sv
// ntt_op_sequencer: issues NTT / INTT / MultiplyNTTs butterfly operations one per handshake,
// with BF_LATENCY drain bubbles after each layer.
module ntt_op_sequencer
   import ntt_op_sequencer_pkg::*;
#(
   parameter int unsigned BF_LATENCY = 4
) (
   input logic                 clk,
   input logic                 rst,
   ntt_op_sequencer_if.master  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t     state_q, state_d;
   op_mode_t   mode_q, mode_d;
   logic [2:0] l_q, l_d;
   logic [6:0] o_q, o_d;
   logic [3:0] d_q, d_d;
   bf_op_t     op_q, op_d;
   logic       last_layer;
   logic [7:0] gen_a, gen_b;
   logic [6:0] gen_k;
   // addresses are generated from the next state so the op register holds them while stalled
   ntt_addr_gen u_addr_gen (
      .mode_i     (mode_d),
      .layer_i    (l_d),
      .op_i       (o_d),
      .addr_a_o   (gen_a),
      .addr_b_o   (gen_b),
      .zeta_idx_o (gen_k)
   );
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      l_d = l_q;
      o_d = o_q;
      d_d = d_q;
      last_layer = (l_q == final_layer(mode_q));
      case (state_q)
         IDLE: if (bus.start_i && bus.mode_i != 2'd3) begin
            state_d = ISSUE;
            mode_d = op_mode_t'(bus.mode_i);
            l_d = '0;
            o_d = '0;
         end
         ISSUE: if (bus.op_ready_i) begin
            o_d = o_q + 7'd1;
            if (o_q == 7'(OPS_PER_LAYER - 1)) begin
               d_d = '0;
               state_d = (BF_LATENCY != 0) ? DRAIN : last_layer ? DONE : ISSUE;
               l_d = (BF_LATENCY == 0 && !last_layer) ? l_q + 3'd1 : l_q;
            end
         end
         DRAIN: begin
            d_d = d_q + 4'd1;
            if (d_q == 4'(BF_LATENCY - 1)) begin
               state_d = last_layer ? DONE : ISSUE;
               l_d = last_layer ? l_q : l_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      op_d = '0;
      if (state_d == ISSUE)
         op_d = '{addr_a: gen_a, addr_b: gen_b,
                  zeta: (mode_d == MODE_MUL) ? ZETA_MUL_TABLE[gen_k] : ZETA_NTT_TABLE[gen_k],
                  layer: l_d, layer_last: &o_d, op_last: &o_d && l_d == final_layer(mode_d)};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q <= MODE_NTT;
         l_q <= '0;
         o_q <= '0;
         d_q <= '0;
         op_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         l_q <= l_d;
         o_q <= o_d;
         d_q <= d_d;
         op_q <= op_d;
      end
   end
   assign bus.busy_o = (state_q != IDLE);
   assign bus.done_o = (state_q == DONE);
   assign bus.op_valid_o = (state_q == ISSUE);
   assign bus.addr_a_o = op_q.addr_a;
   assign bus.addr_b_o = op_q.addr_b;
   assign bus.zeta_o = op_q.zeta;
   assign bus.layer_o = op_q.layer;
   assign bus.layer_last_o = op_q.layer_last;
   assign bus.op_last_o = op_q.op_last;
endmodule

// File: tb/tb_ntt_op_sequencer.sv
// tb_ntt_op_sequencer: directed checks of the op sequencer with BF_LATENCY 4 and 0 instances
// sharing one stimulus; obs0 selects which instance is observed.
module tb_ntt_op_sequencer;
   import ntt_op_sequencer_pkg::*;
   logic clk = 0, rst = 1, start = 0, ready = 1, obs0 = 0;
   logic [1:0] mode = 0;
   int vectors = 0, errors = 0;
   logic [32:0] exp_q[$], cap[$];
   ntt_op_sequencer_if bus4();
   ntt_op_sequencer_if bus0();
   assign bus4.start_i = start;
   assign bus4.mode_i = mode;
   assign bus4.op_ready_i = ready;
   assign bus0.start_i = start;
   assign bus0.mode_i = mode;
   assign bus0.op_ready_i = ready;
   ntt_op_sequencer #(.BF_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   ntt_op_sequencer #(.BF_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   always #5 clk = ~clk;
   logic [32:0] cur;
   logic o_valid, o_busy, o_done;
   assign cur = obs0 ? {bus0.layer_o, bus0.addr_a_o, bus0.addr_b_o, bus0.zeta_o, bus0.layer_last_o, bus0.op_last_o}
                     : {bus4.layer_o, bus4.addr_a_o, bus4.addr_b_o, bus4.zeta_o, bus4.layer_last_o, bus4.op_last_o};
   assign o_valid = obs0 ? bus0.op_valid_o : bus4.op_valid_o;
   assign o_busy = obs0 ? bus0.busy_o : bus4.busy_o;
   assign o_done = obs0 ? bus0.done_o : bus4.done_o;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // expected op stream written as the reference loops: k walks the zeta table per group
   task automatic build_exp(input int m);
      int k, len, cnt;
      logic [11:0] z;
      exp_q.delete();
      if (m == 2) begin
         for (int i = 0; i < 128; i++) begin
            z = ZETA_NTT_TABLE[64 + i / 2];
            if (i % 2 == 1) z = 12'(3329 - int'(z));
            exp_q.push_back({3'd0, 8'(2 * i), 8'(2 * i + 1), z, i == 127, i == 127});
         end
      end else begin
         k = (m == 0) ? 1 : 127;
         for (int l = 0; l < 7; l++) begin
            len = (m == 0) ? (128 >> l) : (2 << l);
            cnt = 0;
            for (int s = 0; s < 256; s += 2 * len) begin
               z = ZETA_NTT_TABLE[k];
               k += (m == 0) ? 1 : -1;
               for (int j = s; j < s + len; j++) begin
                  exp_q.push_back({3'(l), 8'(j), 8'(j + len), z, cnt == 127, cnt == 127 && l == 6});
                  cnt++;
               end
            end
         end
      end
   endtask

   task automatic go(input logic [1:0] m);
      @(negedge clk);
      start = 1;
      mode = m;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_idle();
      int c = 0;
      ready = 1;
      while ((bus0.busy_o || bus4.busy_o) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("idle", {bus0.busy_o, bus4.busy_o}, 0);
   endtask

   // n counts cycles after the start-sampling edge; n=1 is the first possible op_valid cycle
   task automatic run_job(input logic [1:0] m, input int exp_done, input bit rnd, input int bf);
      int idx = 0, gap = 0, dcnt = 0, n = 1, extra = 0;
      bit stalled = 0;
      logic [32:0] snap = '0;
      build_exp(int'(m));
      cap.delete();
      ready = 1;
      go(m);
      chk("busy_start", o_busy, 1);
      while (dcnt == 0 && n < 5000) begin
         if (stalled) chk("hold", {o_valid, cur}, {1'b1, snap});
         if (o_done) begin
            dcnt++;
            chk("busy_at_done", o_busy, 1);
            chk("ops_at_done", idx, exp_q.size());
            if (exp_done > 0) chk("done_cycle", n, exp_done);
         end
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 0;
         if (o_valid && ready) begin
            if (idx > 0 && idx % 128 == 0) begin
               chk("drain_gap", gap, bf);
               gap = 0;
            end
            if (idx < exp_q.size()) chk("op", cur, exp_q[idx]);
            else chk("extra_op", idx, exp_q.size() - 1);
            cap.push_back(cur);
            idx++;
         end else if (o_valid) begin
            stalled = 1;
            snap = cur;
         end else if (idx > 0) gap++;
         @(negedge clk);
         n++;
      end
      chk("done_seen", dcnt, 1);
      repeat (4) begin
         @(negedge clk);
         if (o_done) extra++;
      end
      chk("done_once", extra, 0);
      chk("busy_end", o_busy, 0);
      wait_idle();
   endtask

   task automatic hand(input string tag, input int i, input int a, input int b, input int z);
      if (i < cap.size()) chk(tag, cap[i][29:2], {8'(a), 8'(b), 12'(z)});
      else chk(tag, cap.size(), i + 1);
   endtask

   initial begin
      int hs, dn;
      repeat (2) @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_fields", cur, 0);
      rst = 0;
      @(negedge clk);
      go(3);
      chk("illegal_busy", o_busy, 0);
      repeat (3) @(negedge clk);
      chk("illegal_idle", {o_busy, o_valid}, 0);
      run_job(0, 925, 0, 4);
      hand("ntt_op0", 0, 0, 128, 1729);
      hand("ntt_op1", 1, 1, 129, 1729);
      hand("ntt_l1_op0", 128, 0, 64, 2580);
      hand("ntt_l1_op64", 192, 128, 192, 3289);
      hand("ntt_final", 895, 253, 255, 2154);
      if (cap.size() == 896) chk("ntt_final_flags", cap[895][1:0], 2'b11);
      run_job(1, 925, 0, 4);
      hand("intt_op0", 0, 0, 2, 2154);
      hand("intt_final", 895, 127, 255, 1729);
      run_job(2, 133, 0, 4);
      hand("mul_op0", 0, 0, 1, 17);
      hand("mul_op127", 127, 254, 255, 1175);
      run_job(0, -1, 1, 4);
      chk("bp_count", cap.size(), 896);
      go(0);
      hs = 0;
      for (int c = 0; c < 1000; c++) begin
         if (o_valid) begin
            if (hs == 11) chk("start_in_issue", cur[29:2], {8'd11, 8'd139, 12'd1729});
            if (hs == 300) break;
            start = (hs == 10);
            if (hs == 10) mode = 2;
            hs++;
         end else start = 0;
         @(negedge clk);
      end
      start = 0;
      chk("op300", cur, {3'd2, 8'd76, 8'd108, 12'd630, 1'b0, 1'b0});
      rst = 1;
      #1;
      chk("abort_valid", o_valid, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_fields", cur, 0);
      dn = 0;
      repeat (2) begin
         @(negedge clk);
         if (o_done) dn++;
      end
      rst = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_done) dn++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_idle", o_busy, 0);
      run_job(0, 925, 0, 4);
      hand("restart_op0", 0, 0, 128, 1729);
      obs0 = 1;
      run_job(0, 897, 0, 0);
      hand("bf0_op0", 0, 0, 128, 1729);
      hand("bf0_final", 895, 253, 255, 2154);
      obs0 = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
